uart_tx_framer: RTL

//  Transmit-side UART framer. Accepts a byte from the host, drives the parity stage
//  (parity_load / parity_data_out) and consumes its registered result (parity_in). Serialises

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_framer_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_framer.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - host write handshake and parity-stage link of the TX framer
interface uart_tx_framer_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       parity_load;
  logic [7:0] parity_data_out;
  logic       parity_in;

  modport slave (
    input  tx_start, tx_data, parity_in,
    output tx_busy, tx_done, parity_load, parity_data_out
  );

  modport master (
    output tx_start, tx_data, parity_in,
    input  tx_busy, tx_done, parity_load, parity_data_out
  );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with restart, shared by TX and RX
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, 8 data LSB-first, optional parity, 1-2 stops
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_framer_if.slave   bus,
  output logic              tx_serial
);

  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_tx_state_t state, state_d;
  logic [7:0]     shift, shift_d;
  logic [7:0]     pdata, pdata_d;
  logic [2:0]     bit_cnt, bit_cnt_d;
  logic           serial_d;
  logic           done;
  logic           restart;
  logic           bit_tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift     <= '0;
      pdata     <= '0;
      bit_cnt   <= '0;
      tx_serial <= 1'b1;
    end else begin
      state     <= state_d;
      shift     <= shift_d;
      pdata     <= pdata_d;
      bit_cnt   <= bit_cnt_d;
      tx_serial <= serial_d;
    end
  end

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    pdata_d   = pdata;
    bit_cnt_d = bit_cnt;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          state_d = LOAD;
          shift_d = bus.tx_data;
          pdata_d = bus.tx_data;
        end
      end
      LOAD: state_d = START;
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == LAST_DATA) state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value is registered from the next state so it stays aligned with the FSM.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = bus.parity_in ^ PAR_ODD;
      default: serial_d = 1'b1;
    endcase
  end

  // Baud count restarts on every state entry and is held clear while idle.
  assign restart             = (state_d != state) || (state == IDLE);
  assign bus.tx_busy         = (state != IDLE);
  assign bus.tx_done         = done;
  assign bus.parity_load     = (state == LOAD);
  assign bus.parity_data_out = pdata;

endmodule
